jk_reg_bank: RTL and testbench

//   Parametrised WIDTH-bit register bank built on per-bit JK flip-flop semantics.

---
 rtl/jk_reg_bank.sv | 140 ++++++++++++++
 tb/tb_jk_reg_bank.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/jk_reg_bank.sv
// jk_reg_bank
//   WIDTH-bit register bank built on per-bit JK flip-flop semantics.
//   Every bit is a JK cell. The operating mode only decides what drives each
//   cell's J and K inputs:
//     mode 00 : J/K taken from the j/k ports.
//     mode 01 : up count. Bit i toggles (J=K=1) when bits i-1..0 are all 1.
//     mode 10 : down count. Bit i toggles when bits i-1..0 are all 0.
//     mode 11 : shift left. Each cell is forced to the value of its right-hand
//               neighbour (J=v, K=~v). ser_in enters bit 0.
//   Update priority at each edge: rst > load > en; otherwise q holds.
//
// Parameters
//   WIDTH    number of bits (2..32)
//   RST_VAL  value q takes on reset
//
// Ports
//   clk      clock, rising edge
//   rst      synchronous active-high reset
//   en       update enable (load is not gated by en)
//   mode     00 JK, 01 count up, 10 count down, 11 shift left
//   j, k     per-bit J/K inputs (mode 00 only)
//   load, d  synchronous parallel load
//   ser_in   serial input into bit 0 (mode 11)
//   q        registered state
//   qb       ~q (combinational)
//   ser_out  q[WIDTH-1] (combinational)
//   tc       terminal count: all-ones in mode 01, zero in mode 10, else 0
//   chg      (JKR_CHANGE_EN only) registered; 1 for the cycle after an edge
//            that changed q
//
// Configuration macro: JKR_CHANGE_EN (default undefined) adds the chg output.
module jk_reg_bank #(
   parameter int               WIDTH   = 4,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] j,
   input  logic [WIDTH-1:0] k,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   input  logic             ser_in,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qb,
   output logic             ser_out,
   output logic             tc
`ifdef JKR_CHANGE_EN
   ,
   output logic             chg
`endif
);

   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] w_j;
   logic [WIDTH-1:0] w_k;
   logic [WIDTH-1:0] w_t_up;
   logic [WIDTH-1:0] w_t_dn;
   logic [WIDTH-1:0] w_shift;
   logic [WIDTH-1:0] w_jk_nxt;
   logic [WIDTH-1:0] w_q_nxt;

   // Toggle masks for the counters: running AND of the lower bits (up) or of
   // their complements (down). Bit 0 always toggles.
   always_comb begin
      logic w_all1;
      logic w_all0;
      w_t_up = '0;
      w_t_dn = '0;
      w_all1 = 1'b1;
      w_all0 = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
         w_t_up[i] = w_all1;
         w_t_dn[i] = w_all0;
         w_all1    = w_all1 & r_q[i];
         w_all0    = w_all0 & ~r_q[i];
      end
   end

   assign w_shift = {r_q[WIDTH-2:0], ser_in};

   always_comb begin
      w_j = j;
      w_k = k;
      unique case (mode)
         2'b00: begin
            w_j = j;
            w_k = k;
         end
         2'b01: begin
            w_j = w_t_up;
            w_k = w_t_up;
         end
         2'b10: begin
            w_j = w_t_dn;
            w_k = w_t_dn;
         end
         default: begin
            w_j = w_shift;
            w_k = ~w_shift;
         end
      endcase
   end

   // Characteristic JK equation: Q+ = J&~Q | ~K&Q, applied bitwise.
   assign w_jk_nxt = (w_j & ~r_q) | (~w_k & r_q);

   always_comb begin
      w_q_nxt = r_q;
      if (rst)       w_q_nxt = RST_VAL;
      else if (load) w_q_nxt = d;
      else if (en)   w_q_nxt = w_jk_nxt;
   end

   always_ff @(posedge clk) begin
      r_q <= w_q_nxt;
   end

`ifdef JKR_CHANGE_EN
   // Copy of q from the previous cycle; chg flags edges where q moved.
   logic [WIDTH-1:0] r_q_prev;
   logic             r_chg;

   always_ff @(posedge clk) begin
      r_q_prev <= w_q_nxt;
      if (rst) r_chg <= 1'b0;
      else     r_chg <= (w_q_nxt != r_q_prev);
   end

   assign chg = r_chg;
`endif

   assign q       = r_q;
   assign qb      = ~r_q;
   assign ser_out = r_q[WIDTH-1];
   assign tc      = ((mode == 2'b01) && (r_q == {WIDTH{1'b1}})) ||
                    ((mode == 2'b10) && (r_q == '0));

endmodule

// File: tb/tb_jk_reg_bank.sv
module tb_jk_reg_bank;
   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst, en, load, ser_in;
   logic [1:0]   mode;
   logic [W-1:0] j, k, d;
   logic [W-1:0] q, qb;
   logic         ser_out, tc;
`ifdef JKR_CHANGE_EN
   logic         chg;
`endif

   int checks   = 0;
   int failures = 0;
   logic [W-1:0] m_q;   // reference model state

   jk_reg_bank #(.WIDTH(W), .RST_VAL(4'b0000)) dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j), .k(k),
      .load(load), .d(d), .ser_in(ser_in),
      .q(q), .qb(qb), .ser_out(ser_out), .tc(tc)
`ifdef JKR_CHANGE_EN
      , .chg(chg)
`endif
   );

   always #5 clk = ~clk;

   // Behavioural next-state from the rules: arithmetic for counters, concat
   // for shift, JK truth table per bit.
   function automatic logic [W-1:0] model_next(input logic [W-1:0] cq);
      logic [W-1:0] n;
      if (rst)       return 4'b0000;
      if (load)      return d;
      if (!en)       return cq;
      case (mode)
         2'd0: begin
            n = cq;
            for (int i = 0; i < W; i++)
               case ({j[i], k[i]})
                  2'b01: n[i] = 1'b0;
                  2'b10: n[i] = 1'b1;
                  2'b11: n[i] = ~cq[i];
                  default: n[i] = cq[i];
               endcase
            return n;
         end
         2'd1: return W'((int'(cq) + 1) % (1 << W));
         2'd2: return W'((int'(cq) + (1 << W) - 1) % (1 << W));
         default: return {cq[W-2:0], ser_in};
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rst = 0; en = 0; load = 0; ser_in = 0; mode = 0; j = 0; k = 0; d = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1; load = 1; d = 4'b1111;
      step();
      rst = 0; load = 0;
      checks++; if (q !== 4'b0000) begin failures++; $display("FAIL reset_q got=%b exp=0000", q); end
      checks++; if (qb !== 4'b1111) begin failures++; $display("FAIL reset_qb got=%b exp=1111", qb); end
      checks++; if (tc !== 1'b0) begin failures++; $display("FAIL reset_tc got=%b exp=0", tc); end
   endtask

   task automatic test_jk();
      mode = 2'b00; en = 1; j = 4'b1010; k = 4'b0110;
      step();
      checks++; if (q !== 4'b1010) begin failures++; $display("FAIL jk_1 got=%b exp=1010", q); end
      step();
      checks++; if (q !== 4'b1000) begin failures++; $display("FAIL jk_2 got=%b exp=1000", q); end
      en = 0;
   endtask

   task automatic test_count_up();
      load = 1; d = 4'b1110; step(); load = 0;
      mode = 2'b01; en = 1;
      step();
      checks++; if (q !== 4'b1111) begin failures++; $display("FAIL up_q got=%b exp=1111", q); end
      checks++; if (tc !== 1'b1) begin failures++; $display("FAIL up_tc got=%b exp=1", tc); end
      step();
      checks++; if (q !== 4'b0000) begin failures++; $display("FAIL up_wrap got=%b exp=0000", q); end
      checks++; if (tc !== 1'b0) begin failures++; $display("FAIL up_wrap_tc got=%b exp=0", tc); end
      en = 0; step(); step();
      checks++; if (q !== 4'b0000) begin failures++; $display("FAIL up_hold got=%b exp=0000", q); end
   endtask

   task automatic test_count_down();
      load = 1; d = 4'b0001; step(); load = 0;
      mode = 2'b10; en = 1;
      step();
      checks++; if (q !== 4'b0000) begin failures++; $display("FAIL dn_q got=%b exp=0000", q); end
      checks++; if (tc !== 1'b1) begin failures++; $display("FAIL dn_tc got=%b exp=1", tc); end
      step();
      checks++; if (q !== 4'b1111) begin failures++; $display("FAIL dn_wrap got=%b exp=1111", q); end
      rst = 1; step(); rst = 0;
      checks++; if (q !== 4'b0000) begin failures++; $display("FAIL dn_rst got=%b exp=0000", q); end
      en = 0;
   endtask

   task automatic test_shift();
      load = 1; d = 4'b1001; step(); load = 0;
      mode = 2'b11; en = 1; ser_in = 1; #1;
      checks++; if (ser_out !== 1'b1) begin failures++; $display("FAIL sh_serout got=%b exp=1", ser_out); end
      checks++; if (tc !== 1'b0) begin failures++; $display("FAIL sh_tc got=%b exp=0", tc); end
      step();
      checks++; if (q !== 4'b0011) begin failures++; $display("FAIL sh_1 got=%b exp=0011", q); end
      ser_in = 0; step();
      checks++; if (q !== 4'b0110) begin failures++; $display("FAIL sh_2 got=%b exp=0110", q); end
      en = 0;
   endtask

`ifdef JKR_CHANGE_EN
   task automatic test_chg();
      load = 1; d = 4'b0101; step(); load = 0;
      mode = 2'b00; en = 1; j = 0; k = 0;
      step();
      checks++; if (chg !== 1'b0) begin failures++; $display("FAIL chg_hold got=%b exp=0", chg); end
      load = 1; d = 4'b0101; step();
      checks++; if (chg !== 1'b0) begin failures++; $display("FAIL chg_same got=%b exp=0", chg); end
      d = 4'b0110; step(); load = 0;
      checks++; if (chg !== 1'b1) begin failures++; $display("FAIL chg_set got=%b exp=1", chg); end
      step();
      checks++; if (chg !== 1'b0) begin failures++; $display("FAIL chg_clr got=%b exp=0", chg); end
      en = 0;
   endtask
`endif

   task automatic test_random();
      logic [W-1:0] nq;
      logic         etc;
      rst = 1; step(); rst = 0;
      m_q = 4'b0000;
      for (int n = 0; n < 300; n++) begin
         rst    = ($urandom_range(0, 19) == 0);
         load   = ($urandom_range(0, 7) == 0);
         en     = ($urandom_range(0, 3) != 0);
         mode   = 2'($urandom_range(0, 3));
         j      = W'($urandom); k = W'($urandom); d = W'($urandom);
         ser_in = 1'($urandom);
         #1;
         etc = (mode == 2'd1 && m_q == 4'b1111) || (mode == 2'd2 && m_q == 4'b0000);
         checks++; if (tc !== etc) begin failures++; $display("FAIL rnd_tc n=%0d got=%b exp=%b", n, tc, etc); end
         checks++; if (qb !== ~m_q) begin failures++; $display("FAIL rnd_qb n=%0d got=%b exp=%b", n, qb, ~m_q); end
         checks++; if (ser_out !== m_q[W-1]) begin failures++; $display("FAIL rnd_serout n=%0d got=%b exp=%b", n, ser_out, m_q[W-1]); end
         nq = model_next(m_q);
         step();
         checks++; if (q !== nq) begin failures++; $display("FAIL rnd_q n=%0d got=%b exp=%b", n, q, nq); end
`ifdef JKR_CHANGE_EN
         checks++; if (chg !== (!rst && nq != m_q)) begin failures++; $display("FAIL rnd_chg n=%0d got=%b exp=%b", n, chg, (!rst && nq != m_q)); end
`endif
         m_q = nq;
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      @(negedge clk);
      test_reset();
      test_jk();
      test_count_up();
      test_count_down();
      test_shift();
`ifdef JKR_CHANGE_EN
      test_chg();
`endif
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
